shared_reg_arbiter: RTL and testbench

Round-robin write arbiter for one shared WIDTH-bit D-flop register. Up to NREQ requesters post write requests with a req/ack handshake; the arbiter picks one winner per clock, loads its data into the shared register and pulses that requester's ack. It sits between producer blocks and any register they would otherwise contend for, so the register always has exactly one writer per cycle.

---
 rtl/shared_reg_arb_pkg.sv | 21 ++
 rtl/shared_reg_arbiter_rr_pick.sv | 29 ++
 rtl/shared_reg_arbiter.sv | 101 ++++++++++
 tb/tb_shared_reg_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared-register write arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package shared_reg_arb_pkg;

  // LOCKED is always declared so the encoding is identical in every build.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit of elig from ptr upward, wrapping.
// Latency: combinational. Backpressure: none; the caller decides what is eligible.
// Ports: elig (eligible vector), ptr (search start) -> vld (any eligible), idx (winner index).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] pos;

  always_comb begin
    vld = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!vld && elig[pos]) begin
        vld = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register; one winner per clock.
// Latency: req/wdata sampled at edge k, q/ack/gnt_id valid after edge k (one cycle).
// Backpressure: req is held until its one-cycle ack; an acked requester is masked for that cycle.
// Ports: req/wdata in, lock in (only with SHARED_REG_ARB_LOCK_EN), ack/gnt_id/q/busy out.
// Optional feature macro: SHARED_REG_ARB_LOCK_EN adds the lock port and the LOCKED state.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    wdata,
`ifdef SHARED_REG_ARB_LOCK_EN
  input  logic [NREQ-1:0]          lock,
`endif
  output logic [NREQ-1:0]          ack,
  output logic [idx_w(NREQ)-1:0]   gnt_id,
  output logic [WIDTH-1:0]         q,
  output logic                     busy
);

  localparam int IW = idx_w(NREQ);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     win;
  logic              win_vld;
  logic [NREQ-1:0]   elig;
  logic [WIDTH-1:0]  lane [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lane[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

`ifdef SHARED_REG_ARB_LOCK_EN
  logic [IW-1:0] owner;
  logic          hold;

  // The lock holds only while the owner keeps lock high; on the edge it drops,
  // arbitration is already open to everyone again.
  assign hold = (state == LOCKED) && lock[owner];

  always_comb begin
    elig = req & ~ack;
    if (hold) begin
      elig        = '0;
      elig[owner] = req[owner] & ~ack[owner];
    end
  end
`else
  assign elig = req & ~ack;
`endif

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .elig (elig),
    .ptr  (ptr),
    .vld  (win_vld),
    .idx  (win)
  );

  assign busy = (|ack) || (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      ack    <= '0;
      gnt_id <= '0;
      ptr    <= '0;
      state  <= IDLE;
`ifdef SHARED_REG_ARB_LOCK_EN
      owner  <= '0;
`endif
    end else begin
      ack <= '0;
      if (win_vld) begin
        q        <= lane[win];
        ack[win] <= 1'b1;
        gnt_id   <= win;
        ptr      <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
`ifdef SHARED_REG_ARB_LOCK_EN
      if (win_vld && lock[win]) begin
        state <= LOCKED;
        owner <= win;
      end else if (hold) begin
        state <= LOCKED;
      end else begin
        state <= win_vld ? ACK : IDLE;
      end
`else
      state <= win_vld ? ACK : IDLE;
`endif
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed vector table, reset/lock sequences,
// then randomized traffic against a queue-free behavioural model of the arbitration rules.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   wdata;
  logic [N-1:0]     lock_drv;
  logic [N-1:0]     ack;
  logic [1:0]       gnt_id;
  logic [W-1:0]     q;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  shared_reg_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wdata  (wdata),
`ifdef SHARED_REG_ARB_LOCK_EN
    .lock   (lock_drv),
`endif
    .ack    (ack),
    .gnt_id (gnt_id),
    .q      (q),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_ptr, m_last, m_gnt, m_owner;
  bit         m_locked;
  logic [W-1:0] m_q;

  task automatic model_reset();
    m_ptr = 0; m_last = -1; m_gnt = 0; m_owner = 0; m_locked = 0; m_q = '0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] d,
                            input logic [N-1:0] lk);
    int w;
    bit held;
    w = -1;
    held = m_locked && lk[m_owner];
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (w < 0 && r[i] && i != m_last && (!held || i == m_owner)) w = i;
    end
    if (w >= 0) begin
      m_q    = d[w*W +: W];
      m_gnt  = w;
      m_ptr  = (w + 1) % N;
      m_last = w;
      if (lk[w]) m_owner = w;
      m_locked = lk[w] || held;
    end else begin
      m_last   = -1;
      m_locked = held;
    end
  endtask

  function automatic logic [N-1:0] m_ack();
    return (m_last >= 0) ? N'(1 << m_last) : '0;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_step(req, wdata, lock_drv);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ack"},  32'(ack),    32'(m_ack()));
    chk({tag, ".q"},    32'(q),      32'(m_q));
    chk({tag, ".gnt"},  32'(gnt_id), 32'(m_gnt));
    chk({tag, ".busy"}, 32'(busy),   32'((m_last >= 0) || m_locked));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic [1:0]     gnt;
  } vec_t;

  vec_t tbl [16];

  int wait_cnt [N];
  logic [N-1:0] prev_ack;

  initial begin
    // Directed table, starting from reset (ptr = 0).
    tbl[0]  = '{4'b1111, 32'h44332211, 4'b0001, 8'h11, 2'd0};
    tbl[1]  = '{4'b1110, 32'h44332211, 4'b0010, 8'h22, 2'd1};
    tbl[2]  = '{4'b1100, 32'h44332211, 4'b0100, 8'h33, 2'd2};
    tbl[3]  = '{4'b1000, 32'h44332211, 4'b1000, 8'h44, 2'd3};
    tbl[4]  = '{4'b0000, 32'h44332211, 4'b0000, 8'h44, 2'd3};
    tbl[5]  = '{4'b0100, 32'h005A0000, 4'b0100, 8'h5A, 2'd2};
    tbl[6]  = '{4'b0100, 32'h005A0000, 4'b0000, 8'h5A, 2'd2};
    tbl[7]  = '{4'b0100, 32'h005A0000, 4'b0100, 8'h5A, 2'd2};
    tbl[8]  = '{4'b0000, 32'h005A0000, 4'b0000, 8'h5A, 2'd2};
    tbl[9]  = '{4'b1001, 32'h77000066, 4'b1000, 8'h77, 2'd3};
    tbl[10] = '{4'b0001, 32'h77000066, 4'b0001, 8'h66, 2'd0};
    tbl[11] = '{4'b0000, 32'h77000066, 4'b0000, 8'h66, 2'd0};
    tbl[12] = '{4'b0011, 32'h0000A166, 4'b0010, 8'hA1, 2'd1};
    tbl[13] = '{4'b0010, 32'h0000B266, 4'b0000, 8'hA1, 2'd1};
    tbl[14] = '{4'b0010, 32'h0000B266, 4'b0010, 8'hB2, 2'd1};
    tbl[15] = '{4'b0000, 32'h0000B266, 4'b0000, 8'hB2, 2'd1};

    rst_n = 1'b0; req = '0; wdata = '0; lock_drv = '0;
    model_reset();
    #2;
    chk("rst.ack",  32'(ack),    32'h0);
    chk("rst.q",    32'(q),      32'h0);
    chk("rst.gnt",  32'(gnt_id), 32'h0);
    chk("rst.busy", 32'(busy),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 16; v++) begin
      req = tbl[v].req;
      wdata = tbl[v].wdata;
      step();
      chk($sformatf("vec%0d.ack", v),  32'(ack),    32'(tbl[v].ack));
      chk($sformatf("vec%0d.q", v),    32'(q),      32'(tbl[v].q));
      chk($sformatf("vec%0d.gnt", v),  32'(gnt_id), 32'(tbl[v].gnt));
      chk($sformatf("vec%0d.busy", v), 32'(busy),   32'(|tbl[v].ack));
    end

    // Asynchronous reset with an ack in flight.
    req = 4'b1111; wdata = 32'h44332211;
    step();
    step();
    check_model("preburst");
    rst_n = 1'b0;
    #1;
    chk("midrst.ack",  32'(ack),    32'h0);
    chk("midrst.q",    32'(q),      32'h0);
    chk("midrst.gnt",  32'(gnt_id), 32'h0);
    chk("midrst.busy", 32'(busy),   32'h0);
    model_reset();
    @(negedge clk);
    req = 4'b1010;
    rst_n = 1'b1;
    step();
    chk("postrst.ack", 32'(ack), 32'h2);
    chk("postrst.q",   32'(q),   32'h22);
    check_model("postrst");

`ifdef SHARED_REG_ARB_LOCK_EN
    req = '0;
    do_reset();
    req = 4'b0001; step();          // ptr -> 1
    req = 4'b0000; step();
    req = 4'b0111; lock_drv = 4'b0010; wdata = 32'h00332211;
    step();
    chk("lock.first.ack", 32'(ack), 32'h2);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("lock.c%0d.others", c), 32'(ack & 4'b0101), 32'h0);
      chk($sformatf("lock.c%0d.busy", c), 32'(busy), 32'h1);
      check_model($sformatf("lock.c%0d", c));
    end
    lock_drv = 4'b0000; req = 4'b0101;
    step();
    chk("unlock.ack", 32'(ack), 32'h4);
    chk("unlock.q",   32'(q),   32'h33);
    check_model("unlock");
`endif

    // Randomized traffic: req held until ack, optionally held one extra cycle.
    req = '0; lock_drv = '0;
    do_reset();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
      end
      wdata = $urandom;
`ifdef SHARED_REG_ARB_LOCK_EN
      for (int i = 0; i < N; i++) lock_drv[i] = ($urandom_range(0, 5) == 0);
`endif
      prev_ack = ack;
      step();
      check_model($sformatf("rnd%0d", c));
`ifndef SHARED_REG_ARB_LOCK_EN
      // Fairness: a pending request sees at most N-1 other writes before its own.
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          chk($sformatf("rnd%0d.fair%0d", c, i), 32'(wait_cnt[i] <= N - 1), 32'h1);
          wait_cnt[i] = 0;
        end else if (req[i] && !prev_ack[i] && (|ack)) begin
          wait_cnt[i]++;
        end else if (!req[i]) begin
          wait_cnt[i] = 0;
        end
      end
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
